// File: rtl/bram_if_pkg.sv
// Shared definitions for users of the 64 KiB byte-wide block RAM port.
package bram_if_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Address arithmetic wraps naturally at the top of the 64 KiB space.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/bram_burst_master_if.sv
// Command, byte-stream and RAM-port signals of the burst master, bundled.
interface bram_burst_master_if;
  import bram_if_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len_m1;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  logic              busy;
  logic              done;

  logic              mem_mode;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_byte_in;
  logic [DATA_W-1:0] mem_byte_out;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len_m1,
    input  wr_data, wr_valid, rd_ready, mem_byte_out,
    output cmd_ready, wr_ready, rd_data, rd_valid,
    output busy, done, mem_mode, mem_address, mem_byte_in
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len_m1,
    output wr_data, wr_valid, rd_ready, mem_byte_out,
    input  cmd_ready, wr_ready, rd_data, rd_valid,
    input  busy, done, mem_mode, mem_address, mem_byte_in
  );

endinterface

// File: rtl/bram_burst_master_skid.sv
// Two-entry byte FIFO absorbing RAM read latency so the read stream can stall.
module byte_skid_buffer
  import bram_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic [1:0]        occ;
  logic              do_pop;
  logic              do_push;

  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'd2) || do_pop);

  // head is always the oldest byte, so the output is a plain register.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout      = head;
  assign valid     = (occ != 2'd0);
  assign occupancy = occ;

endmodule

// File: rtl/bram_burst_master.sv
// Burst initiator for the byte-wide BRAM: sequences one RAM access per cycle
// for a commanded read or write burst, with a credit-limited read path.
module bram_burst_master
  import bram_if_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  bram_burst_master_if.master bus
);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic              inflight;
  logic              issued_all;

  logic [1:0]        occ;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;

  logic              pop;
  logic              credit_ok;
  logic              issue;
  logic              wr_fire;
  logic              rd_finish;

  assign pop       = buf_valid && bus.rd_ready;
  // Buffered plus in-flight bytes may never exceed the two buffer slots.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign issue     = (state == READ) && !issued_all && credit_ok;
  assign wr_fire   = (state == WRITE) && bus.wr_valid;
  assign rd_finish = (state == READ) && issued_all && !inflight &&
                     ((occ == 2'd0) || ((occ == 2'd1) && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      inflight   <= 1'b0;
      issued_all <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cur_addr   <= bus.cmd_addr;
            remaining  <= bus.cmd_len_m1;
            issued_all <= 1'b0;
            state      <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            cur_addr  <= next_addr(cur_addr);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == '0) state <= DONE;
          end
        end
        READ: begin
          if (issue) begin
            cur_addr  <= next_addr(cur_addr);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == '0) issued_all <= 1'b1;
          end
          if (rd_finish) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lands on mem_byte_out the cycle after its issue, exactly when
  // inflight is set, so inflight doubles as the buffer push strobe.
  byte_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .din       (bus.mem_byte_out),
    .pop       (pop),
    .dout      (buf_data),
    .valid     (buf_valid),
    .occupancy (occ)
  );

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.wr_ready    = (state == WRITE);
  assign bus.mem_mode    = wr_fire ? MEM_WRITE : MEM_READ;
  assign bus.mem_address = cur_addr;
  assign bus.mem_byte_in = (state == WRITE) ? bus.wr_data : '0;
  assign bus.rd_valid    = buf_valid;
  assign bus.rd_data     = buf_data;

endmodule

// File: tb/tb_bram_burst_master.sv
// Directed bench for bram_burst_master with a behavioural registered-read RAM.
module tb_bram_burst_master;
  import bram_if_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic preload;

  always #5 clk = ~clk;

  bram_burst_master_if bus();

  bram_burst_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [7:0] mem [0:65535];

  function automatic logic [7:0] pattern(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // RAM model: write on the edge, registered read of the presented address.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pattern(16'(i));
    end else if (bus.mem_mode) begin
      mem[bus.mem_address] <= bus.mem_byte_in;
    end
    bus.mem_byte_out <= mem[bus.mem_address];
  end

  int n_checks;
  int n_fail;
  int tick_no;
  int issued, popped, max_out, done_cnt;
  int first_valid, last_pop, done_tick;
  logic        prev_read;
  logic [15:0] prev_addr;
  logic [7:0]  rx [$];
  logic [15:0] wlog_addr [$];
  logic [7:0]  wlog_data [$];
  logic [7:0]  wd [4];
  logic [15:0] wa [4];

  logic        s_cmd_ready, s_wr_ready, s_rd_valid, s_busy, s_done, s_mem_mode;
  logic [7:0]  s_rd_data, s_mem_byte_in;
  logic [15:0] s_mem_address;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_monitor();
    issued = 0; popped = 0; max_out = 0; done_cnt = 0;
    first_valid = -1; last_pop = -1; done_tick = -1; tick_no = 0;
    rx.delete(); wlog_addr.delete(); wlog_data.delete();
  endtask

  // Snapshot one cycle at the falling edge, log traffic, then advance past
  // the next rising edge. Issues show up as address steps during READ.
  task automatic tick();
    @(negedge clk);
    s_cmd_ready   = bus.cmd_ready;
    s_wr_ready    = bus.wr_ready;
    s_rd_valid    = bus.rd_valid;
    s_busy        = bus.busy;
    s_done        = bus.done;
    s_mem_mode    = bus.mem_mode;
    s_rd_data     = bus.rd_data;
    s_mem_byte_in = bus.mem_byte_in;
    s_mem_address = bus.mem_address;
    if (prev_read && (s_mem_address != prev_addr)) issued++;
    if (issued - popped > max_out) max_out = issued - popped;
    if (s_rd_valid && first_valid < 0) first_valid = tick_no;
    if (s_rd_valid && bus.rd_ready) begin
      rx.push_back(s_rd_data);
      popped++;
      last_pop = tick_no;
    end
    if (s_done) begin
      done_cnt++;
      done_tick = tick_no;
    end
    if (s_mem_mode) begin
      wlog_addr.push_back(s_mem_address);
      wlog_data.push_back(s_mem_byte_in);
    end
    prev_read = s_busy && !s_wr_ready && !s_done;
    prev_addr = s_mem_address;
    @(posedge clk);
    #1;
    tick_no++;
  endtask

  task automatic applyStimulus(input logic w, input logic [15:0] addr, input logic [15:0] len_m1);
    clear_monitor();
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = w;
    bus.cmd_addr   = addr;
    bus.cmd_len_m1 = len_m1;
    tick();
    checkOutput("cmd_accept", 32'(s_cmd_ready), 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  // Four-byte write of wd[] expected at addresses wa[]; pat bit t gates wr_valid.
  task automatic run_write(input logic [15:0] addr, input logic [15:0] pat, input string tag);
    int i = 0;
    int t = 0;
    applyStimulus(1'b1, addr, 16'd3);
    while (i < 4 && t < 64) begin
      bus.wr_valid = pat[t % 16];
      bus.wr_data  = bus.wr_valid ? wd[i] : 8'hEE;
      tick();
      if (bus.wr_valid && s_wr_ready) i++;
      t++;
    end
    checkOutput({tag, "_bytes_taken"}, 32'(i), 32'd4);
    bus.wr_valid = 1'b0;
    tick();
    checkOutput({tag, "_done"}, 32'(s_done), 32'd1);
    tick();
    checkOutput({tag, "_idle"}, 32'(s_cmd_ready), 32'd1);
    checkOutput({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, "_mem_writes"}, 32'(wlog_addr.size()), 32'd4);
    for (int k = 0; k < 4 && k < wlog_addr.size(); k++) begin
      checkOutput($sformatf("%s_addr%0d", tag, k), 32'(wlog_addr[k]), 32'(wa[k]));
      checkOutput($sformatf("%s_data%0d", tag, k), 32'(wlog_data[k]), 32'(wd[k]));
    end
  endtask

  task automatic run_read(input logic [15:0] addr, input logic [15:0] len_m1,
                          input bit toggle, input int budget);
    int t = 0;
    applyStimulus(1'b0, addr, len_m1);
    while (done_tick < 0 && t < budget) begin
      bus.rd_ready = toggle ? ((tick_no % 4 == 0) || (tick_no % 4 == 3)) : 1'b1;
      tick();
      t++;
    end
    bus.rd_ready = 1'b0;
    if (done_tick < 0) checkOutput("rd_done_seen", 32'd0, 32'd1);
    tick();
    checkOutput("rd_back_to_idle", 32'(s_cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int errs;
    logic [15:0] a;
    n_checks = 0; n_fail = 0;
    prev_read = 1'b0; prev_addr = '0;
    rst = 1'b1; preload = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len_m1 = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    clear_monitor();

    $display("[TB] reset values");
    tick(); tick();
    checkOutput("rst_cmd_ready",   32'(s_cmd_ready),   32'd1);
    checkOutput("rst_wr_ready",    32'(s_wr_ready),    32'd0);
    checkOutput("rst_rd_valid",    32'(s_rd_valid),    32'd0);
    checkOutput("rst_rd_data",     32'(s_rd_data),     32'd0);
    checkOutput("rst_busy",        32'(s_busy),        32'd0);
    checkOutput("rst_done",        32'(s_done),        32'd0);
    checkOutput("rst_mem_mode",    32'(s_mem_mode),    32'd0);
    checkOutput("rst_mem_address", 32'(s_mem_address), 32'd0);
    checkOutput("rst_mem_byte_in", 32'(s_mem_byte_in), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] write 4 bytes at 0x0010");
    wd = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    wa = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    run_write(16'h0010, 16'hFFFF, "wr1");

    $display("[TB] read back at full rate");
    run_read(16'h0010, 16'd3, 1'b0, 50);
    checkOutput("rd1_count", 32'(rx.size()), 32'd4);
    for (int k = 0; k < 4 && k < rx.size(); k++)
      checkOutput($sformatf("rd1_byte%0d", k), 32'(rx[k]), 32'(wd[k]));
    checkOutput("rd1_first_valid", 32'(first_valid), 32'd3);
    checkOutput("rd1_last_pop",    32'(last_pop),    32'd6);
    checkOutput("rd1_done_tick",   32'(done_tick),   32'd7);
    checkOutput("rd1_done_count",  32'(done_cnt),    32'd1);
    checkOutput("rd1_outstanding", 32'(max_out),     32'd2);

    $display("[TB] read back with rd_ready toggling");
    run_read(16'h0010, 16'd3, 1'b1, 60);
    checkOutput("rd2_count", 32'(rx.size()), 32'd4);
    for (int k = 0; k < 4 && k < rx.size(); k++)
      checkOutput($sformatf("rd2_byte%0d", k), 32'(rx[k]), 32'(wd[k]));
    checkOutput("rd2_done_after_pop", 32'(done_tick), 32'(last_pop + 1));
    checkOutput("rd2_done_count",     32'(done_cnt),  32'd1);
    checkOutput("rd2_outstanding",    32'(max_out),   32'd2);

    $display("[TB] wrapping write with wr_valid gaps");
    wd = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    wa = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    run_write(16'hFFFE, 16'b1111_1111_1100_1101, "wr2");
    run_read(16'hFFFE, 16'd3, 1'b0, 50);
    checkOutput("rd3_count", 32'(rx.size()), 32'd4);
    for (int k = 0; k < 4 && k < rx.size(); k++)
      checkOutput($sformatf("rd3_byte%0d", k), 32'(rx[k]), 32'(wd[k]));

    $display("[TB] full 64 KiB read");
    preload = 1'b1;
    tick();
    preload = 1'b0;
    run_read(16'h8000, 16'hFFFF, 1'b0, 66000);
    checkOutput("full_count", 32'(rx.size()), 32'd65536);
    errs = 0;
    for (int i = 0; i < rx.size(); i++) begin
      a = 16'h8000 + 16'(i);
      if (rx[i] !== pattern(a)) errs++;
    end
    checkOutput("full_mismatches", 32'(errs),     32'd0);
    checkOutput("full_done_count", 32'(done_cnt), 32'd1);
    checkOutput("full_outstanding", 32'(max_out), 32'd2);

    $display("[TB] reset in the middle of an 8-byte read");
    applyStimulus(1'b0, 16'h0010, 16'd7);
    begin
      int t = 0;
      while (rx.size() < 2 && t < 20) begin
        bus.rd_ready = 1'b1;
        tick();
        t++;
      end
    end
    checkOutput("mid_popped", 32'(rx.size()), 32'd2);
    if (rx.size() >= 2) begin
      checkOutput("mid_byte0", 32'(rx[0]), 32'(pattern(16'h0010)));
      checkOutput("mid_byte1", 32'(rx[1]), 32'(pattern(16'h0011)));
    end
    done_cnt = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("mid_rst_rd_valid",  32'(s_rd_valid),  32'd0);
    checkOutput("mid_rst_busy",      32'(s_busy),      32'd0);
    checkOutput("mid_rst_mem_mode",  32'(s_mem_mode),  32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(s_cmd_ready), 32'd1);
    checkOutput("mid_rst_done",      32'(s_done),      32'd0);
    tick(); tick(); tick();
    checkOutput("mid_rst_no_done", 32'(done_cnt), 32'd0);
    bus.rd_ready = 1'b0;

    run_read(16'h0042, 16'd0, 1'b0, 30);
    checkOutput("post_rst_count",      32'(rx.size()), 32'd1);
    if (rx.size() >= 1)
      checkOutput("post_rst_byte",     32'(rx[0]),     32'(pattern(16'h0042)));
    checkOutput("post_rst_done_count", 32'(done_cnt),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
